// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the MIPS multi-cycle control unit.
// States, opcode/func constants, ALU operation codes and datapath select values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_R_EX,
        S_R_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_IMM_EX,
        S_IMM_WB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_CONST  = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_ALUOUT = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type func field to ALU operation, with a flag for supported arithmetic funcs.
// Latency: combinational. Backpressure: none.
// JR is not reported valid here; the FSM recognises it separately.
module alu_op_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       func_valid
);

    always_comb begin
        alu_op     = ALU_ADD;
        func_valid = 1'b1;
        case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: func_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM driving every select/enable of the MIPS multi-cycle datapath.
// Latency: outputs decode the registered state (plus zero in BRANCH); 2-5 cycles per instruction.
// Backpressure: none; MC_LINK_EN adds JAL/JR, otherwise they decode as illegal.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       x,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       Sel1,
    output logic       Sel2,
    output logic       Sel3,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOperation,
    output logic [1:0] PCSrc,
    output logic       illegal
);

    state_t     state;
    state_t     next;
    logic [2:0] dec_op;
    logic       func_valid;

    alu_op_decoder u_alu_op_decoder (
        .func       (func),
        .alu_op     (dec_op),
        .func_valid (func_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= next;
    end

    // Everything defaults to 0, so holding reset low silences all strobes.
    always_comb begin
        next         = S_FETCH;
        x            = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        Sel1         = 1'b0;
        Sel2         = 1'b0;
        Sel3         = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        ALUOperation = ALU_AND;
        PCSrc        = PC_ALU;
        illegal      = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    MemRead      = 1'b1;
                    IRWrite      = 1'b1;
                    x            = 1'b1;
                    ALUSrcB      = SRCB_CONST;
                    ALUOperation = ALU_ADD;
                    next         = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcB      = SRCB_IMM_SH;
                    ALUOperation = ALU_ADD;
                    case (opcode)
                        OP_RTYPE: begin
`ifdef MC_LINK_EN
                            if (func == FN_JR) next = S_JR;
                            else
`endif
                            if (func_valid) next = S_R_EX;
                            else            illegal = 1'b1;
                        end
                        OP_LW, OP_SW:     next = S_MEM_ADDR;
                        OP_BEQ:           next = S_BRANCH;
                        OP_J:             next = S_JUMP;
`ifdef MC_LINK_EN
                        OP_JAL:           next = S_JAL;
`endif
                        OP_ADDI, OP_SLTI: next = S_IMM_EX;
                        default:          illegal = 1'b1;
                    endcase
                end
                S_R_EX: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_B;
                    ALUOperation = dec_op;
                    next         = S_R_WB;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_MEM_ADDR: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_IMM;
                    ALUOperation = ALU_ADD;
                    next         = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    next    = S_MEM_WB;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_B;
                    ALUOperation = ALU_SUB;
                    PCSrc        = PC_ALUOUT;
                    x            = zero;
                end
                S_JUMP: begin
                    PCSrc = PC_JUMP;
                    x     = 1'b1;
                end
`ifdef MC_LINK_EN
                // PC already holds PC+4 here, so it is the link value as-is.
                S_JAL: begin
                    PCSrc    = PC_JUMP;
                    x        = 1'b1;
                    RegWrite = 1'b1;
                    Sel1     = 1'b1;
                    Sel2     = 1'b1;
                end
                S_JR: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_CONST;
                    Sel3         = 1'b1;
                    ALUOperation = ALU_ADD;
                    PCSrc        = PC_ALU;
                    x            = 1'b1;
                end
`endif
                S_IMM_EX: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_IMM;
                    ALUOperation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    next         = S_IMM_WB;
                end
                S_IMM_WB: begin
                    RegWrite = 1'b1;
                end
                default: next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed per-cycle vectors for mc_control_fsm; expected outputs are hand-computed.
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       x, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg;
    logic       Sel1, Sel2, Sel3, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOperation;

    mc_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .func         (func),
        .zero         (zero),
        .x            (x),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .RegDst       (RegDst),
        .MemToReg     (MemToReg),
        .Sel1         (Sel1),
        .Sel2         (Sel2),
        .Sel3         (Sel3),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOperation (ALUOperation),
        .PCSrc        (PCSrc),
        .illegal      (illegal)
    );

    // {x,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,MemToReg,Sel1,Sel2,Sel3,ALUSrcA,ALUSrcB,ALUOp,PCSrc,illegal}
    wire [19:0] obs = {x, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
                       Sel1, Sel2, Sel3, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, illegal};

    localparam logic [19:0] E_ZERO     = 20'b0;
    localparam logic [19:0] E_FETCH    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0, 2'b01, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_DECODE   = {12'b0, 2'b11, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_DEC_ILL  = {12'b0, 2'b11, 3'b010, 2'b00, 1'b1};
    localparam logic [19:0] E_REX_SUB  = {11'b0, 1'b1, 2'b00, 3'b110, 2'b00, 1'b0};
    localparam logic [19:0] E_REX_AND  = {11'b0, 1'b1, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [19:0] E_REX_SLT  = {11'b0, 1'b1, 2'b00, 3'b111, 2'b00, 1'b0};
    localparam logic [19:0] E_R_WB     = {5'b0, 1'b1, 1'b1, 5'b0, 8'b0};
    localparam logic [19:0] E_MEM_ADDR = {11'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_MEM_RD   = {1'b0, 1'b1, 1'b1, 9'b0, 8'b0};
    localparam logic [19:0] E_MEM_WB   = {5'b0, 1'b1, 1'b0, 1'b1, 4'b0, 8'b0};
    localparam logic [19:0] E_MEM_WR   = {1'b0, 1'b1, 1'b0, 1'b1, 8'b0, 8'b0};
    localparam logic [19:0] E_BR_T     = {1'b1, 10'b0, 1'b1, 2'b00, 3'b110, 2'b10, 1'b0};
    localparam logic [19:0] E_BR_N     = {1'b0, 10'b0, 1'b1, 2'b00, 3'b110, 2'b10, 1'b0};
    localparam logic [19:0] E_JUMP     = {1'b1, 11'b0, 2'b00, 3'b000, 2'b01, 1'b0};
    localparam logic [19:0] E_JAL      = {1'b1, 4'b0, 1'b1, 2'b0, 1'b1, 1'b1, 2'b0, 2'b00, 3'b000, 2'b01, 1'b0};
    localparam logic [19:0] E_JR       = {1'b1, 9'b0, 1'b1, 1'b1, 2'b01, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_IMM_ADD  = {11'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_IMM_SLT  = {11'b0, 1'b1, 2'b10, 3'b111, 2'b00, 1'b0};
    localparam logic [19:0] E_IMM_WB   = {5'b0, 1'b1, 6'b0, 8'b0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000, SLTI = 6'b001010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [19:0] want;
    } vec_t;

    vec_t  vecs[$];
    string names[$];
    int    tests = 0;
    int    fails = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic [19:0] want, input string nm);
        vecs.push_back('{r, op, fn, z, want});
        names.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [19:0] want);
        tests++;
        if (obs !== want) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, obs, want);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; opcode = '0; func = '0; zero = 1'b0;

        for (int i = 0; i < 3; i++) add(0, LW, 6'h00, 1, E_ZERO, "reset_quiet");
        add(1, LW, 6'h00, 0, E_FETCH, "lw_fetch");
        add(1, LW, 6'h00, 0, E_DECODE, "lw_decode");
        add(1, LW, 6'h00, 0, E_MEM_ADDR, "lw_addr");
        add(1, LW, 6'h00, 0, E_MEM_RD, "lw_rd");
        add(1, LW, 6'h00, 0, E_MEM_WB, "lw_wb");
        add(1, SW, 6'h00, 0, E_FETCH, "sw_fetch");
        add(1, SW, 6'h00, 0, E_DECODE, "sw_decode");
        add(1, SW, 6'h00, 0, E_MEM_ADDR, "sw_addr");
        add(1, SW, 6'h00, 0, E_MEM_WR, "sw_wr");
        add(1, RT, 6'b100010, 0, E_FETCH, "sub_fetch");
        add(1, RT, 6'b100010, 0, E_DECODE, "sub_decode");
        add(1, RT, 6'b100010, 0, E_REX_SUB, "sub_ex");
        add(1, RT, 6'b100010, 0, E_R_WB, "sub_wb");
        add(1, RT, 6'b100100, 0, E_FETCH, "and_fetch");
        add(1, RT, 6'b100100, 0, E_DECODE, "and_decode");
        add(1, RT, 6'b100100, 0, E_REX_AND, "and_ex");
        add(1, RT, 6'b100100, 0, E_R_WB, "and_wb");
        add(1, RT, 6'b101010, 0, E_FETCH, "slt_fetch");
        add(1, RT, 6'b101010, 0, E_DECODE, "slt_decode");
        add(1, RT, 6'b101010, 0, E_REX_SLT, "slt_ex");
        add(1, RT, 6'b101010, 0, E_R_WB, "slt_wb");
        add(1, BEQ, 6'h00, 1, E_FETCH, "beqt_fetch");
        add(1, BEQ, 6'h00, 1, E_DECODE, "beqt_decode");
        add(1, BEQ, 6'h00, 1, E_BR_T, "beqt_branch");
        add(1, BEQ, 6'h00, 0, E_FETCH, "beqn_fetch");
        add(1, BEQ, 6'h00, 0, E_DECODE, "beqn_decode");
        add(1, BEQ, 6'h00, 0, E_BR_N, "beqn_branch");
        add(1, J, 6'h00, 0, E_FETCH, "j_fetch");
        add(1, J, 6'h00, 0, E_DECODE, "j_decode");
        add(1, J, 6'h00, 0, E_JUMP, "j_jump");
        add(1, ADDI, 6'h00, 0, E_FETCH, "addi_fetch");
        add(1, ADDI, 6'h00, 0, E_DECODE, "addi_decode");
        add(1, ADDI, 6'h00, 0, E_IMM_ADD, "addi_ex");
        add(1, ADDI, 6'h00, 0, E_IMM_WB, "addi_wb");
        add(1, SLTI, 6'h00, 0, E_FETCH, "slti_fetch");
        add(1, SLTI, 6'h00, 0, E_DECODE, "slti_decode");
        add(1, SLTI, 6'h00, 0, E_IMM_SLT, "slti_ex");
        add(1, SLTI, 6'h00, 0, E_IMM_WB, "slti_wb");
        add(1, JAL, 6'h00, 0, E_FETCH, "jal_fetch");
`ifdef MC_LINK_EN
        add(1, JAL, 6'h00, 0, E_DECODE, "jal_decode");
        add(1, JAL, 6'h00, 0, E_JAL, "jal_exec");
        add(1, RT, 6'b001000, 0, E_FETCH, "jr_fetch");
        add(1, RT, 6'b001000, 0, E_DECODE, "jr_decode");
        add(1, RT, 6'b001000, 0, E_JR, "jr_exec");
`else
        add(1, JAL, 6'h00, 0, E_DEC_ILL, "jal_illegal");
        add(1, RT, 6'b001000, 0, E_FETCH, "jr_fetch");
        add(1, RT, 6'b001000, 0, E_DEC_ILL, "jr_illegal");
`endif
        add(1, BAD, 6'h00, 0, E_FETCH, "bad_fetch");
        add(1, BAD, 6'h00, 0, E_DEC_ILL, "bad_illegal");
        add(1, RT, 6'b000000, 0, E_FETCH, "badfn_fetch");
        add(1, RT, 6'b000000, 0, E_DEC_ILL, "badfn_illegal");
        add(1, LW, 6'h00, 0, E_FETCH, "abort_fetch");
        add(1, LW, 6'h00, 0, E_DECODE, "abort_decode");
        add(1, LW, 6'h00, 0, E_MEM_ADDR, "abort_addr");
        add(0, LW, 6'h00, 0, E_ZERO, "abort_reset");
        add(1, LW, 6'h00, 0, E_FETCH, "abort_refetch");
        add(1, BEQ, 6'h00, 0, E_DECODE, "zflip_decode");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset  = vecs[i].rst;
            opcode = vecs[i].op;
            func   = vecs[i].fn;
            zero   = vecs[i].z;
            #1;
            check(names[i], vecs[i].want);
        end

        // zero is combinational into x during BRANCH: flip it mid-cycle.
        @(negedge clk);
        zero = 1'b0;
        #1 check("branch_zero_low", E_BR_N);
        zero = 1'b1;
        #1 check("branch_zero_high", E_BR_T);
        @(negedge clk);
        zero = 1'b0;
        #1 check("branch_back_fetch", E_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
